// File: rtl/wb_pkg.sv
// Shared constants for the writeback unit: load funct3 codes, widths and the
// arbitration FSM encoding.
package wb_pkg;

    localparam int REG_IDX_W = 4;
    localparam int XLEN      = 32;
    localparam int NUM_REGS  = 1 << REG_IDX_W;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FORCE = 2'd2
    } wb_state_e;

endpackage

// File: rtl/writeback_unit_load_align.sv
// load_align: picks the addressed byte/halfword out of an aligned memory word
// and sign- or zero-extends it according to the load funct3.
module load_align
    import wb_pkg::*;
(
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_data,
    output logic [XLEN-1:0] o_value
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_data[7:0];
            2'd1:    w_byte = i_data[15:8];
            2'd2:    w_byte = i_data[23:16];
            default: w_byte = i_data[31:24];
        endcase
        // Halfword selection ignores addr_lo[0]; misaligned halves are not split.
        w_half = i_addr_lo[1] ? i_data[31:16] : i_data[15:0];
    end

    always_comb begin
        case (i_funct3)
            F3_LB:   o_value = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_value = {{16{w_half[15]}}, w_half};
            F3_LBU:  o_value = {24'd0, w_byte};
            F3_LHU:  o_value = {16'd0, w_half};
            default: o_value = i_data;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: arbitrates ALU results and held load data onto the register
// file write port and keeps the pending-destination scoreboard.
// Optional macro WB_BYPASS_EN adds forwarding outputs from the rf_* stage.
// Handshake: a transfer occurs on a rising edge where valid && ready; a
// producer whose valid is not accepted keeps valid and payload stable.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic [REG_IDX_W-1:0] issue_rd,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    output logic                 hazard,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [REG_IDX_W-1:0] alu_rd,
    input  logic [XLEN-1:0]      alu_data,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [REG_IDX_W-1:0] mem_rd,
    input  logic [2:0]           mem_funct3,
    input  logic [1:0]           mem_addr_lo,
    input  logic [XLEN-1:0]      mem_data,
    output logic                 rf_we,
    output logic [REG_IDX_W-1:0] rf_rd,
    output logic [XLEN-1:0]      rf_write_data,
`ifdef WB_BYPASS_EN
    output logic                 fwd1_valid,
    output logic [XLEN-1:0]      fwd1_data,
    output logic                 fwd2_valid,
    output logic [XLEN-1:0]      fwd2_data,
`endif
    output logic [1:0]           o_dbg_state
);

    wb_state_e            r_state;
    logic [3:0]           r_starve_cnt;
    logic                 r_hold_valid;
    logic [REG_IDX_W-1:0] r_hold_rd;
    logic [XLEN-1:0]      r_hold_data;
    logic [NUM_REGS-1:0]  r_sb;
    logic                 r_rf_we;
    logic [REG_IDX_W-1:0] r_rf_rd;
    logic [XLEN-1:0]      r_rf_data;

    logic [XLEN-1:0]      w_ext;
    logic                 w_mem_fire;
    logic                 w_commit;
    logic                 w_load_commit;
    logic [REG_IDX_W-1:0] w_commit_rd;
    logic [XLEN-1:0]      w_commit_data;
    logic [NUM_REGS-1:0]  w_sb_next;
    logic [NUM_REGS-1:0]  w_pend;

    load_align u_load_align (
        .i_funct3  (mem_funct3),
        .i_addr_lo (mem_addr_lo),
        .i_data    (mem_data),
        .o_value   (w_ext)
    );

    assign w_mem_fire = mem_valid && !r_hold_valid;

    // Commit source: the held load wins when the ALU is idle or has starved it.
    always_comb begin
        w_commit      = 1'b0;
        w_load_commit = 1'b0;
        w_commit_rd   = alu_rd;
        w_commit_data = alu_data;
        case (r_state)
            ST_IDLE: w_commit = alu_valid;
            ST_HOLD: begin
                w_commit      = 1'b1;
                w_load_commit = !alu_valid;
            end
            ST_FORCE: begin
                w_commit      = 1'b1;
                w_load_commit = 1'b1;
            end
            default: w_commit = 1'b0;
        endcase
        if (w_load_commit) begin
            w_commit_rd   = r_hold_rd;
            w_commit_data = r_hold_data;
        end
    end

    // Clear first, then set, so an issue to the committing index stays pending.
    always_comb begin
        w_sb_next = r_sb;
        if (w_commit)
            w_sb_next[w_commit_rd] = 1'b0;
        if (issue_valid)
            w_sb_next[issue_rd] = 1'b1;
        w_sb_next[0] = 1'b0;
    end

    always_comb begin
        w_pend = r_sb;
`ifdef WB_BYPASS_EN
        if (r_rf_we)
            w_pend[r_rf_rd] = 1'b0;
`endif
        w_pend[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_starve_cnt <= 4'd0;
            r_hold_valid <= 1'b0;
            r_hold_rd    <= '0;
            r_hold_data  <= '0;
            r_sb         <= '0;
            r_rf_we      <= 1'b0;
            r_rf_rd      <= '0;
            r_rf_data    <= '0;
        end else begin
            r_sb    <= w_sb_next;
            r_rf_we <= w_commit && (w_commit_rd != '0);
            if (w_commit) begin
                r_rf_rd   <= w_commit_rd;
                r_rf_data <= w_commit_data;
            end
            if (w_mem_fire) begin
                r_hold_valid <= 1'b1;
                r_hold_rd    <= mem_rd;
                r_hold_data  <= w_ext;
            end else if (w_load_commit) begin
                r_hold_valid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_mem_fire)
                        r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!alu_valid) begin
                        r_state      <= ST_IDLE;
                        r_starve_cnt <= 4'd0;
                    end else begin
                        r_starve_cnt <= r_starve_cnt + 4'd1;
                        if (r_starve_cnt == 4'(STARVE_LIMIT - 1))
                            r_state <= ST_FORCE;
                    end
                end
                ST_FORCE: begin
                    r_state      <= ST_IDLE;
                    r_starve_cnt <= 4'd0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign alu_ready     = reset || (r_state != ST_FORCE);
    assign mem_ready     = reset || !r_hold_valid;
    assign hazard        = !reset && (w_pend[rs1] || w_pend[rs2] || w_pend[issue_rd]);
    assign rf_we         = r_rf_we;
    assign rf_rd         = r_rf_rd;
    assign rf_write_data = r_rf_data;
    assign o_dbg_state   = r_state;

`ifdef WB_BYPASS_EN
    assign fwd1_valid = r_rf_we && (r_rf_rd == rs1) && (rs1 != '0);
    assign fwd2_valid = r_rf_we && (r_rf_rd == rs2) && (rs2 != '0);
    assign fwd1_data  = r_rf_data;
    assign fwd2_data  = r_rf_data;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios then randomized traffic, all
// compared against a transaction-level reference model.
module tb_writeback_unit;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [3:0]  issue_rd, rs1, rs2;
    logic        hazard;
    logic        alu_valid, alu_ready;
    logic [3:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid, mem_ready;
    logic [3:0]  mem_rd;
    logic [2:0]  mem_funct3;
    logic [1:0]  mem_addr_lo;
    logic [31:0] mem_data;
    logic        rf_we;
    logic [3:0]  rf_rd;
    logic [31:0] rf_write_data;
    logic [1:0]  dbg_state;
`ifdef WB_BYPASS_EN
    logic        fwd1_valid, fwd2_valid;
    logic [31:0] fwd1_data, fwd2_data;
`endif

    writeback_unit #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
        .hazard(hazard),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd),
        .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo), .mem_data(mem_data),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_write_data(rf_write_data),
`ifdef WB_BYPASS_EN
        .fwd1_valid(fwd1_valid), .fwd1_data(fwd1_data),
        .fwd2_valid(fwd2_valid), .fwd2_data(fwd2_data),
`endif
        .o_dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_hold;
    logic [3:0]  m_hold_rd;
    logic [31:0] m_hold_data;
    int          m_block;      // ALU wins while a load waits
    bit          m_force;      // next cycle belongs to the waiting load
    bit          m_pend[16];
    bit          m_we;
    logic [3:0]  m_rd;
    logic [31:0] m_data;
    bit          g_alu_rdy, g_mem_rdy;
    logic [35:0] exp_q[$];

    function automatic logic [31:0] model_ext(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * int'(lo))) & 32'hFF;
        h = (w >> (16 * (int'(lo) / 2))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128) ? b - 256 : b;
            3'b001:  return (h >= 32768) ? h - 65536 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic bit pending(input logic [3:0] idx);
        bit p;
        p = (idx != 0) && m_pend[idx];
`ifdef WB_BYPASS_EN
        if (m_we && m_rd == idx) p = 0;
`endif
        return p;
    endfunction

    function automatic void model_reset();
        m_hold = 0; m_hold_rd = 0; m_hold_data = 0; m_block = 0; m_force = 0;
        foreach (m_pend[i]) m_pend[i] = 0;
        m_we = 0; m_rd = 0; m_data = 0;
        exp_q.delete();
    endfunction

    // One clock: check combinational outputs, advance model, check registered outputs.
    task automatic cycle();
        bit exp_alu, exp_mem, exp_haz, load_go, alu_go;
        logic [3:0]  c_rd;
        logic [31:0] c_data;
        logic [35:0] e;
        #1;
        if (reset) begin
            exp_alu = 1; exp_mem = 1; exp_haz = 0;
        end else begin
            exp_alu = !m_force;
            exp_mem = !m_hold;
            exp_haz = pending(rs1) || pending(rs2) || pending(issue_rd);
        end
        check("alu_ready", alu_ready, exp_alu);
        check("mem_ready", mem_ready, exp_mem);
        check("hazard", hazard, exp_haz);
        g_alu_rdy = exp_alu;
        g_mem_rdy = exp_mem;
        if (reset) begin
            model_reset();
        end else begin
            load_go = m_force || (m_hold && !alu_valid);
            alu_go  = !load_go && alu_valid;
            c_rd = 0; c_data = 0;
            if (load_go) begin
                c_rd = m_hold_rd; c_data = m_hold_data;
                m_hold = 0; m_block = 0; m_force = 0;
            end else if (alu_go) begin
                c_rd = alu_rd; c_data = alu_data;
                if (m_hold) begin
                    m_block++;
                    if (m_block == LIMIT) m_force = 1;
                end
            end
            if (mem_valid && exp_mem) begin
                m_hold = 1; m_hold_rd = mem_rd;
                m_hold_data = model_ext(mem_funct3, mem_addr_lo, mem_data);
            end
            m_we = (load_go || alu_go) && (c_rd != 0);
            if (load_go || alu_go) begin
                m_rd = c_rd; m_data = c_data; m_pend[c_rd] = 0;
            end
            if (m_we) exp_q.push_back({c_rd, c_data});
            if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1;
        end
        @(posedge clk);
        #1;
        check("rf_we", rf_we, m_we);
        check("rf_rd", rf_rd, m_rd);
        check("rf_write_data", rf_write_data, m_data);
        if (rf_we) begin
            if (exp_q.size() == 0) check("unexpected_write", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("write_txn", {rf_rd, rf_write_data}, e);
            end
        end
        @(negedge clk);
    endtask

    // ---------------- drivers ----------------
    task automatic drive_quiet();
        issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_funct3 = 0; mem_addr_lo = 0; mem_data = 0;
    endtask

    task automatic load_once(input logic [3:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                             input logic [31:0] w, input logic [31:0] want, input string tag);
        drive_quiet();
        mem_valid = 1; mem_rd = rd; mem_funct3 = f3; mem_addr_lo = lo; mem_data = w;
        cycle();
        drive_quiet();
        cycle();
        check({tag, "_we"}, rf_we, (rd != 0));
        check({tag, "_data"}, rf_write_data, want);
    endtask

    task automatic drive_random();
        logic [3:0] r1, r2, ir;
        bit haz;
        if (!(alu_valid && !g_alu_rdy)) begin
            alu_valid = ($urandom_range(0, 9) < 6);
            alu_rd    = 4'($urandom_range(0, 15));
            alu_data  = $urandom;
        end
        if (!(mem_valid && !g_mem_rdy)) begin
            mem_valid   = ($urandom_range(0, 9) < 3);
            mem_rd      = 4'($urandom_range(0, 15));
            mem_funct3  = 3'($urandom_range(0, 7));
            mem_addr_lo = 2'($urandom_range(0, 3));
            mem_data    = $urandom;
        end
        r1 = 4'($urandom_range(0, 15));
        r2 = 4'($urandom_range(0, 15));
        ir = 4'($urandom_range(0, 15));
        haz = pending(r1) || pending(r2) || pending(ir);
        rs1 = r1; rs2 = r2; issue_rd = ir;
        issue_valid = !haz && ($urandom_range(0, 9) < 4);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        drive_quiet();
        reset = 1;
        model_reset();
        cycle();
        cycle();
        reset = 0;

        // ALU commit to x5 with hazard visible only while pending
        issue_valid = 1; issue_rd = 5;
        cycle();
        drive_quiet();
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF; rs1 = 5;
        #1 check("t1_hazard_N", hazard, 1);
        cycle();
        alu_valid = 0;
        check("t1_we", rf_we, 1);
        check("t1_rd", rf_rd, 5);
        check("t1_data", rf_write_data, 32'hDEADBEEF);
        #1 check("t1_hazard_after", hazard, 0);
        cycle();

        // Load extension cases
        load_once(3, 3'b000, 2'd2, 32'h0080FF11, 32'hFFFFFF80, "lb");
        load_once(3, 3'b100, 2'd2, 32'h0080FF11, 32'h00000080, "lbu");
        load_once(3, 3'b001, 2'd2, 32'h0080FF11, 32'h00000080, "lh");
        load_once(3, 3'b101, 2'd0, 32'h0080FF11, 32'h0000FF11, "lhu");
        load_once(4, 3'b001, 2'd1, 32'h8000_1234, 32'h00001234, "lh_odd");
        load_once(4, 3'b111, 2'd3, 32'hCAFE_F00D, 32'hCAFEF00D, "f3_other");

        // Starvation: ALU streams while a load waits
        drive_quiet();
        mem_valid = 1; mem_rd = 9; mem_funct3 = 3'b010; mem_data = 32'h1234_5678;
        alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
        cycle();
        mem_valid = 0;
        for (int i = 0; i < LIMIT; i++) begin
            alu_rd = 4'(i + 2); alu_data = 32'(i + 32'h100);
            #1 check("starve_alu_ready", alu_ready, 1);
            check("starve_mem_ready", mem_ready, 0);
            cycle();
        end
        alu_rd = 8; alu_data = 32'h200;
        #1 check("force_alu_ready", alu_ready, 0);
        check("force_mem_ready", mem_ready, 0);
        cycle();
        check("force_load_rd", rf_rd, 9);
        check("force_load_data", rf_write_data, 32'h1234_5678);
        #1 check("force_after_ready", alu_ready, 1);
        cycle();
        drive_quiet();
        cycle();

        // Commits to x0
        alu_valid = 1; alu_rd = 0; alu_data = 32'h5555_AAAA;
        issue_valid = 1; issue_rd = 0; rs1 = 0;
        cycle();
        check("x0_alu_we", rf_we, 0);
        check("x0_alu_data", rf_write_data, 32'h5555_AAAA);
        #1 check("x0_hazard", hazard, 0);
        load_once(0, 3'b010, 2'd0, 32'h7777_0000, 32'h7777_0000, "x0_load");

        // Issue and commit of x7 in the same cycle: set wins
        drive_quiet();
        issue_valid = 1; issue_rd = 7;
        cycle();
        drive_quiet();
        issue_valid = 1; issue_rd = 7;
        alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
        cycle();
        drive_quiet();
        rs2 = 7;
        #1 check("sb7_hazard", hazard, 1);
        cycle();
        alu_valid = 1; alu_rd = 7; alu_data = 32'h78; rs2 = 0;
        cycle();
        drive_quiet();
        cycle();

        // Reset while a load is held
        issue_valid = 1; issue_rd = 9;
        mem_valid = 1; mem_rd = 10; mem_funct3 = 3'b010; mem_data = 32'hABCD;
        cycle();
        drive_quiet();
        rs1 = 9;
        reset = 1;
        cycle();
        reset = 0;
        #1 check("rst_mem_ready", mem_ready, 1);
        check("rst_rf_we", rf_we, 0);
        check("rst_hazard", hazard, 0);
        cycle();
        cycle();
        check("rst_no_commit", rf_we, 0);

        // Randomized traffic
        drive_quiet();
        g_alu_rdy = 1; g_mem_rdy = 1;
        for (int n = 0; n < 3000; n++) begin
            drive_random();
            cycle();
        end
        for (int n = 0; n < LIMIT + 4; n++) begin
            if (!(alu_valid && !g_alu_rdy)) alu_valid = 0;
            if (!(mem_valid && !g_mem_rdy)) mem_valid = 0;
            issue_valid = 0;
            cycle();
        end
        check("exp_q_drained", 36'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
